// File: rtl/qsfp_i2c_cmd_arbiter.sv
// qsfp_i2c_cmd_arbiter
//   Shares one I2C command engine between NUM_REQ command sequencers using
//   round-robin arbitration. Each requester posts a single-cycle command pulse.
//   The command is latched, arbitrated, issued to the engine, and answered with a
//   one-cycle completion that carries the read data. A per-command timeout
//   recovers from a hung engine.
// Ports
//   clk, rst             clock, synchronous active-high reset
//   s_pulse/s_rw         per-requester command strobe and read(1)/write(0)
//   s_id/s_addr/s_wdata  per-requester device ID, register address, write data (8 bits each)
//   s_busy               command pending or in flight, per requester
//   s_cmplt/s_err        one-cycle completion / timeout flag to the owning requester
//   s_rdata              read data, valid with any s_cmplt bit
//   m_pulse/m_rw/m_id/m_addr/m_wdata  command to the engine
//   m_rdata/m_cmplt      engine read data and completion
//   dbg_drop             sticky: a pulse arrived while that requester was busy
//   dbg_grant            current/last granted requester
module qsfp_i2c_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     s_pulse,
  input  logic [NUM_REQ-1:0]     s_rw,
  input  logic [8*NUM_REQ-1:0]   s_id,
  input  logic [8*NUM_REQ-1:0]   s_addr,
  input  logic [8*NUM_REQ-1:0]   s_wdata,
  output logic [NUM_REQ-1:0]     s_busy,
  output logic [NUM_REQ-1:0]     s_cmplt,
  output logic [NUM_REQ-1:0]     s_err,
  output logic [7:0]             s_rdata,
  output logic                   m_pulse,
  output logic                   m_rw,
  output logic [7:0]             m_id,
  output logic [7:0]             m_addr,
  output logic [7:0]             m_wdata,
  input  logic [7:0]             m_rdata,
  input  logic                   m_cmplt,
  output logic [NUM_REQ-1:0]     dbg_drop,
  output logic [1:0]             dbg_grant
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  typedef struct packed {
    logic       rw;
    logic [7:0] id;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_t;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] drop_q, drop_d;
  logic [NUM_REQ-1:0] cmplt_q, cmplt_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  cmd_t               cmd_q [NUM_REQ];
  cmd_t               cmd_d [NUM_REQ];
  cmd_t               mcmd_q, mcmd_d;
  logic               m_pulse_q, m_pulse_d;
  logic [1:0]         grant_q, grant_d;
  logic [1:0]         last_q, last_d;
  logic [15:0]        timer_q, timer_d;
  logic [7:0]         rdata_q, rdata_d;

  logic               found;
  logic [1:0]         win;
  int unsigned        idx;

  // Round-robin scan starting one past the last winner. The inner loop keeps
  // every vector index a constant so no variable-width indexing is needed.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_q) + k) % NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (j == idx) && pend_q[j]) begin
          found = 1'b1;
          win   = 2'(j);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    drop_d    = drop_q;
    cmd_d     = cmd_q;
    mcmd_d    = mcmd_q;
    m_pulse_d = 1'b0;
    grant_d   = grant_q;
    last_d    = last_q;
    timer_d   = timer_q;
    rdata_d   = rdata_q;
    cmplt_d   = '0;
    err_d     = '0;

    // Capture only into an idle slot. A requester completing this cycle still
    // has pend set, so its coincident pulse is counted as dropped.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (s_pulse[i]) begin
        if (pend_q[i]) begin
          drop_d[i] = 1'b1;
        end else begin
          cmd_d[i]  = {s_rw[i], s_id[8*i +: 8], s_addr[8*i +: 8], s_wdata[8*i +: 8]};
          pend_d[i] = 1'b1;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = win;
          last_d    = win;
          m_pulse_d = 1'b1;
          for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (win == 2'(j)) mcmd_d = cmd_q[j];
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = TIMEOUT_CYCLES - 16'd1;
        state_d = WAIT;
      end
      WAIT: begin
        // Engine completion takes priority over an expiring timer.
        if (m_cmplt || (timer_q == '0)) begin
          rdata_d = m_cmplt ? m_rdata : 8'hFF;
          for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (grant_q == 2'(j)) begin
              cmplt_d[j] = 1'b1;
              err_d[j]   = ~m_cmplt;
              pend_d[j]  = 1'b0;
            end
          end
          state_d = IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      drop_q    <= '0;
      cmplt_q   <= '0;
      err_q     <= '0;
      cmd_q     <= '{default: '0};
      mcmd_q    <= '0;
      m_pulse_q <= 1'b0;
      grant_q   <= '0;
      last_q    <= 2'(NUM_REQ - 1);
      timer_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
      cmplt_q   <= cmplt_d;
      err_q     <= err_d;
      cmd_q     <= cmd_d;
      mcmd_q    <= mcmd_d;
      m_pulse_q <= m_pulse_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      timer_q   <= timer_d;
      rdata_q   <= rdata_d;
    end
  end

  assign s_busy    = pend_q;
  assign s_cmplt   = cmplt_q;
  assign s_err     = err_q;
  assign s_rdata   = rdata_q;
  assign m_pulse   = m_pulse_q;
  assign m_rw      = mcmd_q.rw;
  assign m_id      = mcmd_q.id;
  assign m_addr    = mcmd_q.addr;
  assign m_wdata   = mcmd_q.wdata;
  assign dbg_drop  = drop_q;
  assign dbg_grant = grant_q;

endmodule

// File: tb/tb_qsfp_i2c_cmd_arbiter.sv
// Bench for qsfp_i2c_cmd_arbiter. Instance A uses the default timeout and
// instance B uses a 16-cycle timeout. Both instances share the requester
// inputs, and sel picks which instance the engine model and monitor serve.
module tb_qsfp_i2c_cmd_arbiter;
  localparam int N = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   s_pulse, s_rw;
  logic [8*N-1:0] s_id, s_addr, s_wdata;
  logic [7:0]     m_rdata;
  logic           eng_cmplt, spur, sel;
  logic           a_mc, b_mc;
  assign a_mc = (eng_cmplt | spur) & ~sel;
  assign b_mc = (eng_cmplt | spur) & sel;

  logic [N-1:0] a_busy, a_cmplt, a_err, a_drop, b_busy, b_cmplt, b_err, b_drop;
  logic [7:0]   a_rdata, a_id, a_addr, a_wdata, b_rdata, b_id, b_addr, b_wdata;
  logic         a_mp, a_rw, b_mp, b_rw;
  logic [1:0]   a_grant, b_grant;

  qsfp_i2c_cmd_arbiter #(.NUM_REQ(N)) dut_a (
    .clk(clk), .rst(rst), .s_pulse(s_pulse), .s_rw(s_rw), .s_id(s_id),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_busy(a_busy), .s_cmplt(a_cmplt),
    .s_err(a_err), .s_rdata(a_rdata), .m_pulse(a_mp), .m_rw(a_rw), .m_id(a_id),
    .m_addr(a_addr), .m_wdata(a_wdata), .m_rdata(m_rdata), .m_cmplt(a_mc),
    .dbg_drop(a_drop), .dbg_grant(a_grant));

  qsfp_i2c_cmd_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16'd16)) dut_b (
    .clk(clk), .rst(rst), .s_pulse(s_pulse), .s_rw(s_rw), .s_id(s_id),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_busy(b_busy), .s_cmplt(b_cmplt),
    .s_err(b_err), .s_rdata(b_rdata), .m_pulse(b_mp), .m_rw(b_rw), .m_id(b_id),
    .m_addr(b_addr), .m_wdata(b_wdata), .m_rdata(m_rdata), .m_cmplt(b_mc),
    .dbg_drop(b_drop), .dbg_grant(b_grant));

  logic [N-1:0] o_busy, o_cmplt, o_err, o_drop;
  logic [7:0]   o_rdata, o_m_id, o_m_addr, o_m_wdata;
  logic         o_m_pulse, o_m_rw;
  logic [1:0]   o_grant;
  always_comb begin
    o_busy = sel ? b_busy : a_busy;     o_cmplt = sel ? b_cmplt : a_cmplt;
    o_err = sel ? b_err : a_err;        o_drop = sel ? b_drop : a_drop;
    o_rdata = sel ? b_rdata : a_rdata;  o_m_id = sel ? b_id : a_id;
    o_m_addr = sel ? b_addr : a_addr;   o_m_wdata = sel ? b_wdata : a_wdata;
    o_m_pulse = sel ? b_mp : a_mp;      o_m_rw = sel ? b_rw : a_rw;
    o_grant = sel ? b_grant : a_grant;
  end

  typedef struct { logic rw; logic [7:0] id; logic [7:0] addr; logic [7:0] wdata; } iss_t;
  typedef struct { int idx; logic [7:0] rdata; logic err; int lat; } cpl_t;
  iss_t q_iss[$];
  cpl_t q_cpl[$];
  iss_t ei;
  cpl_t ec;
  logic [N-1:0] mask;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_mp = 0, n_mp = 0, n_cpl = 0;
  int eng_delay = 5;
  logic [7:0] hang_id = 8'hFF;
  int k, mp0, c0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic rw, input logic [7:0] id, addr, wd);
    s_pulse[i] = 1'b1;
    s_rw[i] = rw;
    s_id[8*i +: 8] = id;
    s_addr[8*i +: 8] = addr;
    s_wdata[8*i +: 8] = wd;
  endtask

  task automatic exp_iss(input logic rw, input logic [7:0] id, addr, wd);
    iss_t s;
    s.rw = rw; s.id = id; s.addr = addr; s.wdata = wd;
    q_iss.push_back(s);
  endtask

  // Expected engine read data is id ^ addr ^ 1A, matching the engine model.
  task automatic exp_cmd(input int i, input logic rw, input logic [7:0] id, addr, wd,
                         input logic hang, input int lat);
    cpl_t c;
    exp_iss(rw, id, addr, wd);
    c.idx = i; c.rdata = hang ? 8'hFF : (id ^ addr ^ 8'h1A); c.err = hang; c.lat = lat;
    q_cpl.push_back(c);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((q_iss.size() != 0 || q_cpl.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, (q_iss.size() == 0 && q_cpl.size() == 0), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    q_iss.delete();
    q_cpl.delete();
    rst = 1'b0;
    tick(1);
  endtask

  // Engine model: answers each issued command after eng_delay cycles unless
  // its ID is hang_id; a reset while waiting abandons the answer.
  initial begin : engine
    logic [7:0] rd;
    logic aborted;
    eng_cmplt = 1'b0;
    m_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && o_m_pulse === 1'b1 && o_m_id !== hang_id) begin
        rd = o_m_id ^ o_m_addr ^ 8'h1A;
        aborted = 1'b0;
        for (int d = 0; d < eng_delay; d++) begin
          @(posedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          #1;
          eng_cmplt = 1'b1;
          m_rdata = rd;
          @(posedge clk);
          #1;
          eng_cmplt = 1'b0;
          m_rdata = 8'h00;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (o_m_pulse === 1'b1) begin
        n_mp++;
        last_mp = cyc;
        chk("iss_expected", q_iss.size() != 0, 1);
        if (q_iss.size() != 0) begin
          ei = q_iss.pop_front();
          chk("m_cmd", {o_m_rw, o_m_id, o_m_addr, o_m_wdata}, {ei.rw, ei.id, ei.addr, ei.wdata});
        end
      end
      if (o_cmplt !== '0) begin
        n_cpl++;
        chk("cpl_expected", q_cpl.size() != 0, 1);
        if (q_cpl.size() != 0) begin
          ec = q_cpl.pop_front();
          mask = '0;
          mask[ec.idx] = 1'b1;
          chk("s_cmplt", o_cmplt, mask);
          chk("s_err", o_err, ec.err ? mask : '0);
          chk("s_rdata", o_rdata, ec.rdata);
          chk("busy_low", o_busy[ec.idx], 0);
          chk("cpl_latency", cyc - last_mp, ec.lat);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sel = 1'b0; spur = 1'b0;
    s_pulse = '0; s_rw = '0; s_id = '0; s_addr = '0; s_wdata = '0;
    tick(3);
    chk("reset_a", {a_busy, a_cmplt, a_err, a_rdata, a_mp, a_rw, a_id, a_addr, a_wdata, a_drop, a_grant}, 0);
    chk("reset_b", {b_busy, b_cmplt, b_err, b_rdata, b_mp, b_rw, b_id, b_addr, b_wdata, b_drop, b_grant}, 0);
    rst = 1'b0;
    tick(1);

    // Single read with a 20-cycle engine response.
    eng_delay = 20;
    req(0, 1'b1, 8'h40, 8'h00, 8'h00);
    exp_cmd(0, 1'b1, 8'h40, 8'h00, 8'h00, 1'b0, 21);
    tick(1); s_pulse = '0;
    chk("t1_busy_T1", {o_busy, o_m_pulse}, {2'b01, 1'b0});
    tick(1);
    chk("t1_mpulse_T2", {o_m_pulse, o_m_rw, o_m_id, o_grant}, {1'b1, 1'b1, 8'h40, 2'd0});
    drain("t1_drain", 40);
    chk("t1_cmplt_1cyc", {o_cmplt, o_err, o_busy}, 0);
    chk("t1_m_held", {o_m_rw, o_m_id, o_m_addr}, {1'b1, 8'h40, 8'h00});

    // Contention, then req0 re-posts in its completion cycle.
    do_reset();
    eng_delay = 5;
    req(0, 1'b0, 8'h50, 8'h10, 8'hAA);
    req(1, 1'b1, 8'h51, 8'h11, 8'hBB);
    exp_cmd(0, 1'b0, 8'h50, 8'h10, 8'hAA, 1'b0, 6);
    exp_cmd(1, 1'b1, 8'h51, 8'h11, 8'hBB, 1'b0, 6);
    tick(1); s_pulse = '0;
    k = 0;
    while (o_cmplt[0] !== 1'b1 && k < 30) begin tick(1); k++; end
    chk("t2_cmplt0_seen", o_cmplt[0], 1);
    chk("t2_no_pulse_C1", o_m_pulse, 0);
    req(0, 1'b1, 8'h52, 8'h12, 8'hCC);
    exp_cmd(0, 1'b1, 8'h52, 8'h12, 8'hCC, 1'b0, 6);
    tick(1); s_pulse = '0;
    chk("t2_req1_pulse_C2", {o_m_pulse, o_m_id, o_grant}, {1'b1, 8'h51, 2'd1});
    drain("t2_drain", 60);
    chk("t2_grant_last", o_grant, 0);
    chk("t2_no_drop", o_drop, 0);

    // Second pulse from a busy requester is dropped.
    do_reset();
    eng_delay = 8;
    mp0 = n_mp;
    req(1, 1'b0, 8'h60, 8'h20, 8'h11);
    exp_cmd(1, 1'b0, 8'h60, 8'h20, 8'h11, 1'b0, 9);
    tick(1); s_pulse = '0;
    tick(2);
    req(1, 1'b1, 8'h61, 8'h21, 8'h22);
    tick(1); s_pulse = '0;
    drain("t4_drain", 40);
    chk("t4_drop", o_drop, 2'b10);
    chk("t4_one_issue", n_mp - mp0, 1);

    // Spurious engine completion while idle.
    tick(2);
    c0 = n_cpl;
    spur = 1'b1;
    tick(1); spur = 1'b0;
    chk("t5_spur_c1", {o_cmplt, o_err}, 0);
    tick(1);
    chk("t5_spur_c2", {o_cmplt, o_err, o_busy}, 0);
    chk("t5_spur_count", n_cpl - c0, 0);

    // Reset while waiting on the engine.
    eng_delay = 30;
    req(0, 1'b1, 8'h66, 8'h26, 8'h00);
    exp_iss(1'b1, 8'h66, 8'h26, 8'h00);
    tick(1); s_pulse = '0;
    tick(8);
    chk("t6_busy_before", o_busy, 2'b01);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_outputs", {o_busy, o_cmplt, o_err, o_rdata, o_m_pulse, o_m_rw, o_m_id,
                           o_m_addr, o_m_wdata, o_drop, o_grant}, 0);
    rst = 1'b0;
    c0 = n_cpl;
    tick(35);
    chk("t6_no_cmplt", n_cpl - c0, 0);
    eng_delay = 4;
    req(1, 1'b0, 8'h80, 8'h30, 8'h44);
    exp_cmd(1, 1'b0, 8'h80, 8'h30, 8'h44, 1'b0, 5);
    tick(1); s_pulse = '0;
    drain("t6_drain", 30);

    // 16-cycle timeout instance.
    sel = 1'b1;
    do_reset();
    hang_id = 8'h70;
    eng_delay = 5;
    req(0, 1'b1, 8'h70, 8'h30, 8'h00);
    exp_cmd(0, 1'b1, 8'h70, 8'h30, 8'h00, 1'b1, 17);
    tick(1); s_pulse = '0;
    req(1, 1'b1, 8'h71, 8'h31, 8'h00);
    exp_cmd(1, 1'b1, 8'h71, 8'h31, 8'h00, 1'b0, 6);
    tick(1); s_pulse = '0;
    drain("t3_drain", 60);
    hang_id = 8'hFF;

    // Completion on the last timer cycle beats the timeout.
    eng_delay = 16;
    req(0, 1'b1, 8'h72, 8'h32, 8'h00);
    exp_cmd(0, 1'b1, 8'h72, 8'h32, 8'h00, 1'b0, 17);
    tick(1); s_pulse = '0;
    drain("t5b_drain", 40);

    // One cycle later is a timeout, and the late engine completion is ignored.
    eng_delay = 17;
    req(0, 1'b1, 8'h73, 8'h33, 8'h00);
    exp_cmd(0, 1'b1, 8'h73, 8'h33, 8'h00, 1'b1, 17);
    tick(1); s_pulse = '0;
    drain("t5c_drain", 40);
    c0 = n_cpl;
    tick(4);
    chk("t5c_late_ignored", n_cpl - c0, 0);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
